// File: rtl/hit_accumulator.sv
// hit_accumulator: ORs per-triangle inside flags into one result bit per point and writes results to sequential memory addresses
module hit_accumulator #(
  parameter int ADDR_W = 12,
  parameter int TRI_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TRI_W-1:0]  num_tris,
  input  logic              in_valid,
  input  logic              in_hit,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_data,
  output logic [ADDR_W:0]   pt_count,
  output logic [ADDR_W:0]   hit_count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [TRI_W-1:0] tri_idx, ntri_q;
  logic acc, res_q, last_q;
  logic accept, close, wrap, launch;
  assign launch = (state == IDLE || state == DONE) && start;
  assign accept = in_valid && in_ready;
  assign close  = accept && (tri_idx == ntri_q - TRI_W'(1) || in_last);
  assign wrap   = mem_addr == '1;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next-state: start launches, a closing flag writes, a write ends on last or address exhaustion
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? ACCUM : state;
      ACCUM:      state_n = close ? WRITE : ACCUM;
      WRITE:      state_n = (last_q || wrap) ? DONE : ACCUM;
      default:    state_n = IDLE;
    endcase
  end
  // state-decoded outputs; mem_data tracks the latched result, which only changes on close
  always_comb begin
    in_ready = state == ACCUM;
    mem_wr   = state == WRITE;
    busy     = state == ACCUM || state == WRITE;
    done     = state == DONE;
    mem_data = res_q;
  end
  // datapath: run setup, per-flag accumulation, and per-point commit of address and counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tri_idx   <= '0;
      ntri_q    <= '0;
      acc       <= 1'b0;
      res_q     <= 1'b0;
      last_q    <= 1'b0;
      mem_addr  <= '0;
      pt_count  <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
    end else if (launch) begin
      tri_idx   <= '0;
      ntri_q    <= (num_tris == '0) ? TRI_W'(1) : num_tris;
      acc       <= 1'b0;
      mem_addr  <= '0;
      pt_count  <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
    end else if (close) begin
      res_q   <= acc | in_hit;
      last_q  <= in_last;
      tri_idx <= '0;
      acc     <= 1'b0;
    end else if (accept) begin
      acc     <= acc | in_hit;
      tri_idx <= tri_idx + TRI_W'(1);
    end else if (state == WRITE) begin
      pt_count  <= pt_count + (ADDR_W+1)'(1);
      hit_count <= hit_count + (ADDR_W+1)'(res_q);
      mem_addr  <= mem_addr + ADDR_W'(1);
      overflow  <= overflow | (!last_q && wrap);
    end
endmodule
